// File: rtl/mem_subsystem.sv
// Memory stage: MAR/MDR registers, 512x32 word RAM and a program loader
// that streams an image into RAM while the CPU is held off.
module mem_subsystem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              RAM_wr,
  output logic [DATA_W-1:0] MDR_out,
  output logic [ADDR_W-1:0] MAR_out,
  output logic              mem_busy,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = 1;

  ld_state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_clip;
  logic              last;
  logic              busy;
  logic              unused_bus_hi;

  // Upper bus bits never reach the MAR.
  assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

  assign len_clip = (ld_len > DEPTH_C) ? DEPTH_C : ld_len;
  assign last     = (ptr == cnt - ONE);
  assign busy     = (state == LOAD);
  assign MAR_out  = mar;
  assign MDR_out  = mdr;

  // Loader state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Loader next-state: a zero-length load still reports completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ld_start)
              state_nxt = (len_clip == '0) ? DONE : LOAD;
      LOAD: if (ld_valid && last)
              state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loader outputs decoded from state.
  always_comb begin
    mem_busy = 1'b0;
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    unique case (state)
      LOAD: begin
        mem_busy = 1'b1;
        ld_ready = 1'b1;
      end
      DONE: ld_done = 1'b1;
      default: ;
    endcase
  end

  // Loader pointer and clipped word count.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE && ld_start) begin
      ptr <= '0;
      cnt <= len_clip;
    end else if (busy && ld_valid) begin
      ptr <= ptr + ONE;
    end
  end

  // MAR/MDR; frozen while the loader owns the RAM, clr wins over loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      mar <= '0;
      mdr <= '0;
    end else if (!busy) begin
      if (clr) begin
        mar <= '0;
        mdr <= '0;
      end else begin
        if (MARin) mar <= bus_in[ADDR_W-1:0];
        if (MDRin) mdr <= Read ? mem[mar] : bus_in;
      end
    end
  end

  // RAM write port: loader owns it during LOAD, otherwise the CPU.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (ld_valid) mem[ptr[ADDR_W-1:0]] <= ld_data;
      end else if (RAM_wr) begin
        mem[mar] <= mdr;
      end
    end
  end

endmodule

// File: tb/tb_mem_subsystem.sv
// Bench for mem_subsystem: directed steps plus random traffic checked
// against a word-array reference model of the memory stage.
module tb_mem_subsystem;

  logic        clk = 1'b0;
  logic        reset, clr, MARin, MDRin, Read, RAM_wr;
  logic [31:0] bus_in;
  logic [31:0] MDR_out;
  logic [8:0]  MAR_out;
  logic        mem_busy;
  logic        ld_start, ld_valid;
  logic [9:0]  ld_len;
  logic [31:0] ld_data;
  logic        ld_ready, ld_done;

  always #5 clk = ~clk;

  mem_subsystem dut (
    .clk(clk), .reset(reset), .clr(clr), .bus_in(bus_in),
    .MARin(MARin), .MDRin(MDRin), .Read(Read), .RAM_wr(RAM_wr),
    .MDR_out(MDR_out), .MAR_out(MAR_out), .mem_busy(mem_busy),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [512];
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  bit          m_act, m_done;
  int          m_ptr, m_total;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    reset = 0; clr = 0; MARin = 0; MDRin = 0; Read = 0; RAM_wr = 0;
    bus_in = 0; ld_start = 0; ld_len = 0; ld_valid = 0; ld_data = 0;
  endtask

  // Advance the model by one clock using the current inputs,
  // clock the DUT, then compare every output.
  task automatic step(input string tag);
    logic [8:0]  n_mar;
    logic [31:0] n_mdr;
    if (reset) begin
      m_mar = 0; m_mdr = 0; m_act = 0; m_done = 0;
    end else begin
      n_mar = m_mar;
      n_mdr = m_mdr;
      if (!m_act) begin
        if (clr) begin
          n_mar = 0; n_mdr = 0;
        end else begin
          if (MARin) n_mar = bus_in[8:0];
          if (MDRin) n_mdr = Read ? ref_mem[m_mar] : bus_in;
        end
        if (RAM_wr) ref_mem[m_mar] = m_mdr;
      end else if (ld_valid) begin
        ref_mem[m_ptr] = ld_data;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_act) begin
        if (ld_valid) begin
          m_ptr++;
          if (m_ptr == m_total) begin
            m_act = 0; m_done = 1;
          end
        end
      end else if (ld_start) begin
        m_total = (ld_len > 10'd512) ? 512 : int'(ld_len);
        m_ptr = 0;
        if (m_total == 0) m_done = 1;
        else m_act = 1;
      end
      m_mar = n_mar;
      m_mdr = n_mdr;
    end
    @(posedge clk); #1;
    chk({tag, ".mar"},   {23'b0, MAR_out}, {23'b0, m_mar});
    chk({tag, ".mdr"},   MDR_out, m_mdr);
    chk({tag, ".busy"},  {31'b0, mem_busy}, {31'b0, m_act});
    chk({tag, ".ready"}, {31'b0, ld_ready}, {31'b0, m_act});
    chk({tag, ".done"},  {31'b0, ld_done}, {31'b0, m_done});
  endtask

  task automatic rd(input logic [8:0] a);
    quiet(); MARin = 1; bus_in = {23'b0, a}; step("rd_mar");
    quiet(); MDRin = 1; Read = 1; step("rd_mdr");
    quiet();
  endtask

  initial begin
    quiet();
    reset = 1; step("rst"); step("rst");
    quiet();
    chk("rst_mar", {23'b0, MAR_out}, 32'd0);
    chk("rst_mdr", MDR_out, 32'd0);

    // Basic write path.
    MARin = 1; bus_in = 32'h5; step("mar5");
    quiet(); MDRin = 1; bus_in = 32'hDEADBEEF; step("mdr_bus");
    quiet(); RAM_wr = 1; step("wr5");
    quiet();
    chk("mar_is5", {23'b0, MAR_out}, 32'd5);
    chk("mdr_dead", MDR_out, 32'hDEADBEEF);
    MDRin = 1; bus_in = 32'h0; step("mdr_zero");
    quiet(); MDRin = 1; Read = 1; step("rd5");
    quiet();
    chk("rd5_val", MDR_out, 32'hDEADBEEF);
    MARin = 1; bus_in = 32'hFFFF_FE07; step("mar_trunc");
    quiet();
    chk("mar_trunc", {23'b0, MAR_out}, 32'h7);

    // Same-cycle read-before-write.
    MARin = 1; bus_in = 32'h5; step("s_mar");
    quiet(); MDRin = 1; bus_in = 32'h22; step("s_mdr22");
    quiet(); RAM_wr = 1; step("s_wr22");
    quiet(); MDRin = 1; bus_in = 32'h11; step("s_mdr11");
    quiet(); RAM_wr = 1; MDRin = 1; Read = 1; step("s_rbw");
    quiet();
    chk("rbw_mdr", MDR_out, 32'h22);
    rd(9'd5);
    chk("rbw_ram", MDR_out, 32'h11);

    // Loader, 3 words with a gap and an ignored MARin.
    ld_start = 1; ld_len = 10'd3; step("l3_start");
    quiet();
    chk("l3_busy", {31'b0, mem_busy}, 32'd1);
    ld_valid = 1; ld_data = 32'hA; MARin = 1; bus_in = 32'h1FF;
    step("l3_a");
    ld_data = 32'hB; step("l3_b");
    ld_valid = 0; step("l3_gap");
    ld_valid = 1; ld_data = 32'hC; step("l3_c");
    quiet();
    chk("l3_done", {31'b0, ld_done}, 32'd1);
    step("l3_idle");
    rd(9'd0); chk("l3_m0", MDR_out, 32'hA);
    rd(9'd1); chk("l3_m1", MDR_out, 32'hB);
    rd(9'd2); chk("l3_m2", MDR_out, 32'hC);

    // Zero-length load.
    ld_start = 1; ld_len = 10'd0; step("l0_start");
    quiet();
    chk("l0_done", {31'b0, ld_done}, 32'd1);
    step("l0_idle");
    rd(9'd1); chk("l0_keep", MDR_out, 32'hB);

    // Oversized load is clipped to the full RAM.
    ld_start = 1; ld_len = 10'd600; step("l600_start");
    quiet();
    for (int n = 0; n < 600;) begin
      ld_valid = ($urandom % 4) != 0;
      ld_data = $urandom;
      if (ld_valid) n++;
      step("l600");
    end
    quiet();
    step("l600_tail");
    chk("l600_ready", {31'b0, ld_ready}, 32'd0);
    rd(9'd511);
    rd(9'd0);
    rd(9'($urandom % 512));

    // Random CPU traffic with occasional short loads.
    for (int i = 0; i < 400; i++) begin
      quiet();
      bus_in = $urandom;
      MARin = $urandom % 2;
      MDRin = $urandom % 2;
      Read = $urandom % 2;
      RAM_wr = $urandom % 3 == 0;
      clr = $urandom % 16 == 0;
      ld_start = $urandom % 40 == 0;
      ld_len = 10'($urandom % 6);
      ld_valid = $urandom % 2;
      ld_data = $urandom;
      step("rnd");
    end
    quiet();
    for (int i = 0; i < 8; i++) step("drain");

    // Reset in the middle of a 4-word load.
    ld_start = 1; ld_len = 10'd4; step("lr_start");
    quiet(); ld_valid = 1; ld_data = 32'h1111; step("lr_w0");
    ld_data = 32'h2222; step("lr_w1");
    quiet(); reset = 1; step("lr_rst");
    quiet();
    chk("lr_busy", {31'b0, mem_busy}, 32'd0);
    step("lr_post");
    chk("lr_nodone", {31'b0, ld_done}, 32'd0);
    rd(9'd0); chk("lr_m0", MDR_out, 32'h1111);
    rd(9'd1); chk("lr_m1", MDR_out, 32'h2222);

    // clr wipes MAR and MDR.
    MARin = 1; bus_in = 32'h9; step("c_mar");
    quiet(); MDRin = 1; bus_in = 32'h5; step("c_mdr");
    quiet();
    chk("c_pre", MDR_out, 32'h5);
    clr = 1; MARin = 1; bus_in = 32'h33; step("c_clr");
    quiet();
    chk("c_mar0", {23'b0, MAR_out}, 32'd0);
    chk("c_mdr0", MDR_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
